muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Issue controller for the iterative `muldiv` HI/LO unit in the 5-stage pipeline. It sits in EX between the decoded HI/LO-class instruction and `muldiv`. It converts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO requests into `start`/`we` strobes and returns MFHI/MFLO data. It also produces the ready/stall handshake that freezes the pipeline while the unit is occupied, and it survives EX-stage flushes.

## Interface
Parameters: none. Op codes driven to the unit are the `SIGNED_MUL`, `UNSIGNED_MUL`, `SIGNED_DIV` and `UNSIGNED_DIV` macros from `muldivop_def.v`.

- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: EX holds a HI/LO-class instruction.
- `req_cmd` in 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MFHI, 5 MFLO, 6 MTHI, 7 MTLO.
- `req_a`, `req_b` in 32: rs and rt operand values.
- `flush` in 1: kills the EX instruction this cycle.
- `req_ready` out 1: the request is consumed this cycle. The pipeline stalls EX when `req_valid & ~req_ready`.
- `rd_data` out 32: MFHI/MFLO result, valid when a MFHI/MFLO request is consumed.
- `ctl_busy` out 1: a unit operation is in flight or queued.
- `md_start` out 1, `md_we` out 1, `md_hilo` out 1 (1 = HI), `md_op` out 2, `md_d1`/`md_d2` out 32: drive the unit's inputs.
- `md_busy` in 1, `md_hi`/`md_lo` in 32: unit status and results.

## Operation
Request handling:
- Eligible: `acc = req_valid & ~flush & ~rst`. `flush` always wins over `req_valid`. Nothing is consumed or strobed for a flushed request.
- `md_*` strobes, `req_ready` and `rd_data` are combinational from state and request.
- Whenever they are not strobing, `md_start` and `md_we` are 0, and `md_d1`/`md_d2`/`md_op` are don't-care.

States are IDLE, LAUNCH and RUN; the state register is 2 bits.

**IDLE**
- MULT/MULTU/DIV/DIVU:
  - `req_ready=1` and `md_start=1`.
  - `md_d1=req_a`, `md_d2=req_b`.
  - `md_op` maps 0→`SIGNED_MUL`, 1→`UNSIGNED_MUL`, 2→`SIGNED_DIV`, 3→`UNSIGNED_DIV`.
  - Next state: LAUNCH.
- MTHI/MTLO:
  - `req_ready=1`, `md_we=1`, `md_d1=req_a`.
  - `md_hilo=1` for MTHI, 0 for MTLO.
  - Stays in IDLE.
- MFHI/MFLO:
  - `req_ready=1`.
  - `rd_data` = `md_hi` for MFHI, `md_lo` for MFLO.
  - Stays in IDLE.

**LAUNCH** (one cycle)
- `md_busy` is ignored.
- `req_ready=0`.
- Next state: RUN.

**RUN**
- `req_ready=0`.
- When `md_busy=0`, next state is IDLE; HI/LO are already valid at that point.

General rules:
- `ctl_busy = (state != IDLE) | qvalid`.
- A flush never aborts an in-flight unit operation; only the EX request is dropped.
- Reset mid-operation: the controller returns to IDLE with the queue empty. The unit is reset by the same `rst`.
- `md_start` and `md_we` are never both 1 in the same cycle.

## Timing
- Reset values: state IDLE, `qvalid=0`, `req_ready=0`, `md_start=0`, `md_we=0`, `ctl_busy=0`.
- A request accepted in cycle C with `md_start=1` is followed by LAUNCH in C+1.
- With unit iteration counts of 5 (MUL) and 10 (DIV), `md_busy` falls visible in C+7 for MUL and C+12 for DIV.
- The controller is back in IDLE in C+8 (MUL) or C+13 (DIV). A dependent MFHI/MFLO is consumed in C+8 or C+13.
- MTHI/MTLO and MFHI/MFLO take one cycle with zero stall in IDLE.
- The unit's HI/LO write lands at the edge ending the `md_we` cycle.

## Configuration
- `MULDIV_CTRL_QUEUE_EN` defined: adds a one-entry command buffer {op, d1, d2, qvalid}.
  - In LAUNCH/RUN with `qvalid=0`, an eligible MULT/DIV-class request is consumed (`req_ready=1`) and written into the buffer.
  - MTHI/MTLO/MFHI/MFLO still stall while `ctl_busy=1`.
  - In IDLE with `qvalid=1`, the buffer issues: `md_start=1` with buffered fields, `req_ready=0` for all requests, `qvalid` clears, next state LAUNCH.
  - A buffered entry is committed: `flush` does not cancel it.
- `MULDIV_CTRL_QUEUE_EN` undefined: no buffer, `qvalid` is tied to 0, and every request stalls outside IDLE.

## Test plan
- Reset, then MULT a=0xFFFFFFFE, b=3, then MFHI/MFLO: MFHI is consumed exactly 8 cycles after MULT and returns `rd_data`=0xFFFFFFFF; MFLO then returns 0xFFFFFFFA. `req_ready=0` in the 7 cycles between.
- DIVU a=100, b=7, then MFHI: MFHI is consumed 13 cycles after DIVU and returns 2; MFLO returns 14. `ctl_busy=1` throughout the 12 intermediate cycles.
- MTHI a=0x12345678 in IDLE: `md_we=1`, `md_hilo=1` in the same cycle and `req_ready=1`. MFHI in the next cycle returns 0x12345678.
- MULT with `flush=1`: `md_start=0`, `req_ready=0`, state stays IDLE. Separately, `rst` asserted 3 cycles into a DIV: IDLE with all strobes 0 immediately, and `ctl_busy=0`.
- With `MULDIV_CTRL_QUEUE_EN`: MULT, then DIV presented in the next cycle, is consumed at once. The DIV issues `md_start` in the cycle the controller first reaches IDLE (MULT accept cycle + 8), with a flush during its wait ignored. A following MFLO is consumed 13 cycles after that issue cycle.

Source files
------------

// File: rtl/muldiv_ctrl_if.sv
// Request/response and muldiv-unit signal bundle for the HI/LO issue controller.
// slave: the controller's view; master: the pipeline/unit side driving it.
interface muldiv_ctrl_if;
    logic        req_valid;
    logic [2:0]  req_cmd;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        flush;
    logic        req_ready;
    logic [31:0] rd_data;
    logic        ctl_busy;
    logic        md_start;
    logic        md_we;
    logic        md_hilo;
    logic [1:0]  md_op;
    logic [31:0] md_d1;
    logic [31:0] md_d2;
    logic        md_busy;
    logic [31:0] md_hi;
    logic [31:0] md_lo;

    modport slave (
        input  req_valid, req_cmd, req_a, req_b, flush, md_busy, md_hi, md_lo,
        output req_ready, rd_data, ctl_busy, md_start, md_we, md_hilo, md_op, md_d1, md_d2
    );

    modport master (
        output req_valid, req_cmd, req_a, req_b, flush, md_busy, md_hi, md_lo,
        input  req_ready, rd_data, ctl_busy, md_start, md_we, md_hilo, md_op, md_d1, md_d2
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// HI/LO issue controller: turns EX-stage MULT/DIV/MTxx/MFxx requests into muldiv strobes.
// Define MULDIV_CTRL_QUEUE_EN to add a one-entry command buffer for back-to-back MULT/DIV.
`ifndef SIGNED_MUL
`define SIGNED_MUL   2'd0
`endif
`ifndef UNSIGNED_MUL
`define UNSIGNED_MUL 2'd1
`endif
`ifndef SIGNED_DIV
`define SIGNED_DIV   2'd2
`endif
`ifndef UNSIGNED_DIV
`define UNSIGNED_DIV 2'd3
`endif

module muldiv_ctrl (
    input  logic         clk,
    input  logic         rst,
    muldiv_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2
    } state_e;

    localparam logic [2:0] CMD_MFHI = 3'd4;
    localparam logic [2:0] CMD_MFLO = 3'd5;
    localparam logic [2:0] CMD_MTHI = 3'd6;
    localparam logic [2:0] CMD_MTLO = 3'd7;

    state_e      state_q, state_d;
    logic        acc_s;
    logic        req_ready_s, md_start_s, md_we_s, md_hilo_s;
    logic [1:0]  md_op_s;
    logic [31:0] md_d1_s, md_d2_s, rd_data_s;
    logic        qvalid_q;

    function automatic logic [1:0] op_map(input logic [1:0] cmd);
        case (cmd)
            2'd0:    op_map = `SIGNED_MUL;
            2'd1:    op_map = `UNSIGNED_MUL;
            2'd2:    op_map = `SIGNED_DIV;
            default: op_map = `UNSIGNED_DIV;
        endcase
    endfunction

    assign acc_s = bus.req_valid & ~bus.flush & ~rst;

`ifdef MULDIV_CTRL_QUEUE_EN
    logic        qvalid_d;
    logic [1:0]  qop_q, qop_d;
    logic [31:0] qd1_q, qd1_d, qd2_q, qd2_d;

    // Command buffer register; a buffered entry survives flushes until issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qvalid_q <= 1'b0;
            qop_q    <= 2'd0;
            qd1_q    <= 32'd0;
            qd2_q    <= 32'd0;
        end else begin
            qvalid_q <= qvalid_d;
            qop_q    <= qop_d;
            qd1_q    <= qd1_d;
            qd2_q    <= qd2_d;
        end
    end
`else
    assign qvalid_q = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, handshake and unit strobes.
    always_comb begin
        state_d     = state_q;
        req_ready_s = 1'b0;
        md_start_s  = 1'b0;
        md_we_s     = 1'b0;
        md_hilo_s   = 1'b0;
        md_op_s     = 2'd0;
        md_d1_s     = 32'd0;
        md_d2_s     = 32'd0;
        rd_data_s   = 32'd0;
`ifdef MULDIV_CTRL_QUEUE_EN
        qvalid_d    = qvalid_q;
        qop_d       = qop_q;
        qd1_d       = qd1_q;
        qd2_d       = qd2_q;
`endif
        case (state_q)
            IDLE: begin
                if (qvalid_q) begin
`ifdef MULDIV_CTRL_QUEUE_EN
                    md_start_s = 1'b1;
                    md_op_s    = qop_q;
                    md_d1_s    = qd1_q;
                    md_d2_s    = qd2_q;
                    qvalid_d   = 1'b0;
                    state_d    = LAUNCH;
`endif
                end else if (acc_s) begin
                    req_ready_s = 1'b1;
                    case (bus.req_cmd)
                        CMD_MFHI: rd_data_s = bus.md_hi;
                        CMD_MFLO: rd_data_s = bus.md_lo;
                        CMD_MTHI, CMD_MTLO: begin
                            md_we_s   = 1'b1;
                            md_hilo_s = (bus.req_cmd == CMD_MTHI);
                            md_d1_s   = bus.req_a;
                        end
                        default: begin
                            md_start_s = 1'b1;
                            md_op_s    = op_map(bus.req_cmd[1:0]);
                            md_d1_s    = bus.req_a;
                            md_d2_s    = bus.req_b;
                            state_d    = LAUNCH;
                        end
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            LAUNCH: state_d = RUN;
            RUN: begin
                // HI/LO are already valid once busy drops, so return straight to IDLE.
                if (!bus.md_busy) begin
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef MULDIV_CTRL_QUEUE_EN
        if ((state_q != IDLE) && acc_s && !bus.req_cmd[2] && !qvalid_q) begin
            req_ready_s = 1'b1;
            qvalid_d    = 1'b1;
            qop_d       = op_map(bus.req_cmd[1:0]);
            qd1_d       = bus.req_a;
            qd2_d       = bus.req_b;
        end else begin
            qvalid_d    = qvalid_d;
        end
`endif
    end

    assign bus.req_ready = req_ready_s;
    assign bus.rd_data   = rd_data_s;
    assign bus.ctl_busy  = (state_q != IDLE) | qvalid_q;
    assign bus.md_start  = md_start_s;
    assign bus.md_we     = md_we_s;
    assign bus.md_hilo   = md_hilo_s;
    assign bus.md_op     = md_op_s;
    assign bus.md_d1     = md_d1_s;
    assign bus.md_d2     = md_d2_s;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized self-checking bench for muldiv_ctrl with a behavioural muldiv unit
// (5/10 iterations) and an arithmetic HI/LO + cycle-accounting reference model.
`ifndef SIGNED_MUL
`define SIGNED_MUL   2'd0
`endif
`ifndef UNSIGNED_MUL
`define UNSIGNED_MUL 2'd1
`endif
`ifndef SIGNED_DIV
`define SIGNED_DIV   2'd2
`endif
`ifndef UNSIGNED_DIV
`define UNSIGNED_DIV 2'd3
`endif

module tb_muldiv_ctrl;
    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   free_cyc = 0;
    logic [31:0] ref_hi = 32'd0;
    logic [31:0] ref_lo = 32'd0;

    muldiv_ctrl_if bus ();

    muldiv_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // {HI, LO} of a MULT/MULTU/DIV/DIVU as plain arithmetic; LO = quotient, HI = remainder.
    function automatic logic [63:0] hilo_calc(input logic [1:0] k, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sp;
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        case (k)
            2'd0: begin
                sp = 64'(sa) * 64'(sb);
                return sp;
            end
            2'd1: return {32'd0, a} * {32'd0, b};
            2'd2: return {32'(sa % sb), 32'(sa / sb)};
            default: return {a % b, a / b};
        endcase
    endfunction

    function automatic logic [1:0] cmd_to_op(input logic [1:0] k);
        case (k)
            2'd0: return `SIGNED_MUL;
            2'd1: return `UNSIGNED_MUL;
            2'd2: return `SIGNED_DIV;
            default: return `UNSIGNED_DIV;
        endcase
    endfunction

    function automatic logic [1:0] op_to_cmd(input logic [1:0] op);
        if (op == `SIGNED_MUL) return 2'd0;
        if (op == `UNSIGNED_MUL) return 2'd1;
        if (op == `SIGNED_DIV) return 2'd2;
        return 2'd3;
    endfunction

    // Behavioural muldiv unit: busy visible 6 cycles (MUL) / 11 cycles (DIV) after start.
    int unsigned u_cnt;
    logic [31:0] u_hi, u_lo, u_phi, u_plo;
    assign bus.md_busy = (u_cnt != 0);
    assign bus.md_hi   = u_hi;
    assign bus.md_lo   = u_lo;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            u_cnt <= 0;
            u_hi  <= 32'd0;
            u_lo  <= 32'd0;
            u_phi <= 32'd0;
            u_plo <= 32'd0;
        end else begin
            if (bus.md_start) begin
                u_cnt <= op_to_cmd(bus.md_op) >= 2'd2 ? 11 : 6;
                {u_phi, u_plo} <= hilo_calc(op_to_cmd(bus.md_op), bus.md_d1, bus.md_d2);
            end else if (u_cnt != 0) begin
                u_cnt <= u_cnt - 1;
                if (u_cnt == 1) begin
                    u_hi <= u_phi;
                    u_lo <= u_plo;
                end
            end
            if (bus.md_we) begin
                if (bus.md_hilo) u_hi <= bus.md_d1;
                else             u_lo <= bus.md_d1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic drive_quiet();
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        bus.req_cmd   = 3'd0;
        bus.req_a     = 32'd0;
        bus.req_b     = 32'd0;
    endtask

    // mode 0: no request, 1: random flushed requests, 2: flushed MULT every cycle.
    task automatic idle(input int n, input int mode);
        bit f;
        for (int k = 0; k < n; k++) begin
            f = (mode == 2) || ((mode == 1) && ($urandom_range(0, 1) == 1));
            bus.req_valid = f;
            bus.flush     = f;
            bus.req_cmd   = (mode == 2) ? 3'd0 : 3'($urandom_range(0, 7));
            bus.req_a     = $urandom;
            bus.req_b     = $urandom;
            @(negedge clk);
            check_eq("idle_ready", bus.req_ready, 1'b0);
            check_eq("idle_start", bus.md_start, 1'b0);
            check_eq("idle_we", bus.md_we, 1'b0);
            check_eq("idle_busy", bus.ctl_busy, cyc < free_cyc);
            @(posedge clk);
            #1;
        end
        drive_quiet();
    endtask

    // Hold a request until consumed; exp_in < 0 means "accepted once the unit is free".
    task automatic issue(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         input int exp_in, output logic [31:0] rd);
        int t0, exp_acc;
        bit done, exp_start;
        logic [63:0] r;
        t0      = cyc;
        exp_acc = (exp_in >= 0) ? exp_in : ((free_cyc > t0) ? free_cyc : t0);
        done    = 1'b0;
        rd      = 32'd0;
        bus.req_valid = 1'b1;
        bus.flush     = 1'b0;
        bus.req_cmd   = cmd;
        bus.req_a     = a;
        bus.req_b     = b;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            check_eq("ctl_busy", bus.ctl_busy, cyc < free_cyc);
            if (bus.req_ready) begin
                done = 1'b1;
                check_eq("accept_cycle", cyc, exp_acc);
                if (!cmd[2]) begin
                    exp_start = (cyc >= free_cyc);
                    check_eq("md_start", bus.md_start, exp_start);
                    check_eq("md_we_on_start", bus.md_we, 1'b0);
                    if (exp_start) begin
                        check_eq("md_op", bus.md_op, cmd_to_op(cmd[1:0]));
                        check_eq("md_d1", bus.md_d1, a);
                        check_eq("md_d2", bus.md_d2, b);
                    end
                    free_cyc = ((cyc > free_cyc) ? cyc : free_cyc) + (cmd[1] ? 13 : 8);
                    r = hilo_calc(cmd[1:0], a, b);
                    ref_hi = r[63:32];
                    ref_lo = r[31:0];
                end else if (cmd[1]) begin
                    check_eq("mt_we", bus.md_we, 1'b1);
                    check_eq("mt_start", bus.md_start, 1'b0);
                    check_eq("mt_hilo", bus.md_hilo, !cmd[0]);
                    check_eq("mt_d1", bus.md_d1, a);
                    if (!cmd[0]) ref_hi = a;
                    else         ref_lo = a;
                end else begin
                    rd = bus.rd_data;
                    check_eq(cmd[0] ? "mflo_data" : "mfhi_data", bus.rd_data, cmd[0] ? ref_lo : ref_hi);
                    check_eq("mf_strobes", {bus.md_start, bus.md_we}, 2'b00);
                end
            end
            @(posedge clk);
            #1;
        end
        drive_quiet();
        if (!done) check_eq("accept_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd, a, b;
        logic [2:0]  cmd;
        int          c0;

        rst = 1'b1;
        drive_quiet();
        @(negedge clk);
        check_eq("rst_ready", bus.req_ready, 1'b0);
        check_eq("rst_strobes", {bus.md_start, bus.md_we}, 2'b00);
        check_eq("rst_busy", bus.ctl_busy, 1'b0);
        bus.req_valid = 1'b1;
        bus.req_cmd   = 3'd0;
        bus.req_a     = 32'd9;
        bus.req_b     = 32'd9;
        @(negedge clk);
        check_eq("rst_req_ready", bus.req_ready, 1'b0);
        check_eq("rst_req_start", bus.md_start, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_quiet();
        free_cyc = cyc;

        // MULT -2*3, dependent MFHI/MFLO.
        issue(3'd0, 32'hFFFF_FFFE, 32'd3, -1, rd);
        issue(3'd4, 32'd0, 32'd0, -1, rd);
        check_eq("mult_hi", rd, 32'hFFFF_FFFF);
        issue(3'd5, 32'd0, 32'd0, -1, rd);
        check_eq("mult_lo", rd, 32'hFFFF_FFFA);

        // DIVU 100/7.
        issue(3'd3, 32'd100, 32'd7, -1, rd);
        issue(3'd4, 32'd0, 32'd0, -1, rd);
        check_eq("divu_hi", rd, 32'd2);
        issue(3'd5, 32'd0, 32'd0, -1, rd);
        check_eq("divu_lo", rd, 32'd14);

        // MTHI then MFHI with zero stall.
        issue(3'd6, 32'h1234_5678, 32'd0, -1, rd);
        issue(3'd4, 32'd0, 32'd0, -1, rd);
        check_eq("mthi_readback", rd, 32'h1234_5678);

        // Flushed MULT is dropped; controller stays idle.
        idle(1, 2);
        idle(1, 0);

        // Reset three cycles into a DIV.
        issue(3'd2, 32'd1000, 32'd3, -1, rd);
        idle(2, 0);
        rst = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_cmd   = 3'd0;
        @(negedge clk);
        check_eq("midrst_ready", bus.req_ready, 1'b0);
        check_eq("midrst_strobes", {bus.md_start, bus.md_we}, 2'b00);
        check_eq("midrst_busy", bus.ctl_busy, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_quiet();
        free_cyc = cyc;
        ref_hi   = 32'd0;
        ref_lo   = 32'd0;
        issue(3'd4, 32'd0, 32'd0, -1, rd);
        check_eq("midrst_hi", rd, 32'd0);

`ifdef MULDIV_CTRL_QUEUE_EN
        // MULT then DIV next cycle: DIV is buffered and issues when IDLE is first reached.
        c0 = cyc;
        issue(3'd0, 32'd5, 32'd6, -1, rd);
        issue(3'd2, 32'hFFFF_FF9C, 32'd7, c0 + 1, rd);
        idle(c0 + 8 - cyc, 2);
        bus.req_valid = 1'b1;
        bus.req_cmd   = 3'd5;
        @(negedge clk);
        check_eq("q_issue_cycle", cyc, c0 + 8);
        check_eq("q_issue_start", bus.md_start, 1'b1);
        check_eq("q_issue_ready", bus.req_ready, 1'b0);
        check_eq("q_issue_op", bus.md_op, `SIGNED_DIV);
        check_eq("q_issue_d1", bus.md_d1, 32'hFFFF_FF9C);
        check_eq("q_issue_d2", bus.md_d2, 32'd7);
        check_eq("q_issue_busy", bus.ctl_busy, 1'b1);
        @(posedge clk);
        #1;
        issue(3'd5, 32'd0, 32'd0, -1, rd);
        check_eq("q_mflo_cycle", cyc - 1, c0 + 21);
        check_eq("q_mflo_data", rd, 32'hFFFF_FFF2);
`else
        c0 = 0;
`endif

        // Randomized traffic with flushed bubbles in between.
        for (int i = 0; i < 60; i++) begin
            cmd = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            if (cmd[2:1] == 2'b01) begin
                if (b == 32'd0) b = 32'd1;
                if (!cmd[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            end
            if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFFF;
`ifdef MULDIV_CTRL_QUEUE_EN
            if (cyc < free_cyc) idle(free_cyc - cyc, 1);
`endif
            issue(cmd, a, b, -1, rd);
            idle($urandom_range(0, 2), 1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
